pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences next-PC selection for the pipelined MIPS core.
- Selects between sequential PC+4, branch target (sign-extended immediate shifted left by 2, added to the branch's PC+4), J/JAL target and JR target.
- Arbitrates redirects against hazard-unit stalls. Holds a pending redirect while the front end is frozen, and drives the IF/ID flush.
- Sits between the hazard unit, the ID-stage jump decode, the EX-stage branch compare and the instruction memory address port.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (word aligned).
- PC_W, 32, PC and address width; fixed at 32 for this core.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hazard unit freeze of IF/ID; PC must not advance
- br_valid  in  1  EX stage holds a resolved conditional branch this cycle
- br_taken  in  1  branch condition true; qualified by br_valid
- br_pc4  in  32  PC+4 of the branch instruction in EX
- br_imm  in  16  branch immediate field of the instruction in EX
- jmp_valid  in  1  ID stage holds J/JAL/JR this cycle
- jmp_reg  in  1  1 = JR (register target), 0 = J/JAL (index target)
- jmp_pc4  in  32  PC+4 of the jump instruction in ID
- jmp_idx  in  26  instr[25:0] of the jump in ID
- jr_target  in  32  forwarded rs value for JR
- pc  out  32  current fetch address to instruction memory
- pc_plus4  out  32  pc + 4, passed to IF/ID register
- if_id_flush  out  1  one-cycle squash of IF/ID contents
- redirect_pend  out  1  a redirect is latched and waiting for stall release

Behaviour:
- Reset (rst_n=0 at edge):
  - pc=RESET_VEC, if_id_flush=0, redirect_pend=0, state=RUN, pending target cleared.
  - Reset overrides everything, including a held PEND.
- Target arithmetic, all mod 2^32, no overflow flag:
  - br_tgt = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00}
  - j_tgt = {jmp_pc4[31:28], jmp_idx, 2'b00}
  - jr_tgt = jr_target
- pc_plus4 = pc + 4 combinationally; 32'hFFFF_FFFC wraps to 0.
- Redirect request this cycle:
  - req = (br_valid & br_taken) | jmp_valid.
  - If both are set, the branch wins (older instruction) and the jump is discarded.
- States:
  - RUN:
    - req & !stall: pc <= selected target, if_id_flush=1 next cycle, stay RUN.
    - req & stall: latch target, go PEND, redirect_pend=1, pc holds.
    - !req & stall: pc holds.
    - else pc <= pc+4.
  - PEND:
    - pc holds while stall=1.
    - New branch requests are ignored; the pending redirect is older.
    - A new taken branch while pending is a hazard-unit protocol violation and is not checked.
    - On stall=0: pc <= latched target, if_id_flush=1 next cycle, redirect_pend=0, go RUN.
- if_id_flush is registered, exactly one cycle wide per accepted redirect, and never asserted while stall=1 on the same cycle it would take effect.
  - If a redirect follows immediately in the next cycle, flush stays high for consecutive cycles.
- Latency:
  - Unstalled redirect: one cycle from request to new pc.
  - Stalled redirect: one cycle after stall deasserts.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_exc (1 bit, registered, reset 0).
  - A JR with jr_target[1:0]!=0 pulses misalign_exc for one cycle when the redirect is accepted.
  - pc loads {jr_target[31:2], 2'b00}.
- Not defined:
  - No port.
  - jr_target is loaded unmodified.

Test Plan:
- Reset: rst_n=0 for 2 cycles, RESET_VEC=32'h0000_0040 -> pc=0x40, flush=0; then 3 free cycles -> pc 0x44, 0x48, 0x4C.
- Backward branch: br_valid=1, br_taken=1, br_pc4=0x100, br_imm=16'hFFFC -> next pc=0xF0, if_id_flush=1 for exactly one cycle.
- Branch vs jump collision: taken branch br_pc4=0x200, imm=0x0004 plus jmp_valid, jmp_idx=0x0000123 in the same cycle -> pc=0x210, jump ignored.
- Stalled redirect: J with jmp_pc4=0x9000_0010, jmp_idx=0x0000400, stall=1 for 3 cycles -> redirect_pend=1, pc frozen; stall drops -> pc=0x9000_1000, flush pulse, redirect_pend=0.
- Wrap and reset mid-PEND: pc=0xFFFF_FFFC free-run -> pc=0; enter PEND, then rst_n=0 -> pc=RESET_VEC, redirect_pend=0, no flush.
- With PC_ALIGN_CHECK_EN: JR jr_target=0x0000_1006 -> pc=0x1004, misalign_exc pulses one cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter owner for the pipelined MIPS core: next-PC select, redirect/stall arbitration, IF/ID flush.
// Optional macro PC_ALIGN_CHECK_EN adds misalign_exc and word-aligns JR targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_pc4,
    input  logic [15:0]     br_imm,
    input  logic            jmp_valid,
    input  logic            jmp_reg,
    input  logic [PC_W-1:0] jmp_pc4,
    input  logic [25:0]     jmp_idx,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            if_id_flush,
    output logic            redirect_pend
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            misalign_exc
`endif
);

    typedef enum logic {RUN, PEND} state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] tgt_reg, tgt_next;
    logic            flush_reg, flush_next;

    logic [PC_W-1:0] br_tgt, j_tgt, jr_tgt, sel_tgt;
    logic            br_take, req;

    // Only the region bits of the jump's PC+4 contribute to the J/JAL target.
    logic unused_pc4_bits;
    assign unused_pc4_bits = ^jmp_pc4[PC_W-5:0];

    assign br_take = br_valid & br_taken;
    assign req     = br_take | jmp_valid;

    assign br_tgt = br_pc4 + {{(PC_W-18){br_imm[15]}}, br_imm, 2'b00};
    assign j_tgt  = {jmp_pc4[PC_W-1:PC_W-4], jmp_idx, 2'b00};
`ifdef PC_ALIGN_CHECK_EN
    assign jr_tgt = {jr_target[PC_W-1:2], 2'b00};
`else
    assign jr_tgt = jr_target;
`endif

    // Branch in EX is older than the jump in ID, so it wins a collision.
    assign sel_tgt = br_take ? br_tgt : (jmp_reg ? jr_tgt : j_tgt);

    assign pc_plus4 = pc_reg + 4;

`ifdef PC_ALIGN_CHECK_EN
    logic mis_req, mis_pend_reg, mis_pend_next, mis_reg, mis_next;
    assign mis_req = !br_take & jmp_valid & jmp_reg & (jr_target[1:0] != 2'b00);
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        tgt_next   = tgt_reg;
        flush_next = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        mis_pend_next = mis_pend_reg;
        mis_next      = 1'b0;
`endif
        case (state_reg)
            RUN: begin
                if (req) begin
                    if (!stall) begin
                        pc_next    = sel_tgt;
                        flush_next = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                        mis_next   = mis_req;
`endif
                    end else begin
                        tgt_next   = sel_tgt;
                        state_next = PEND;
`ifdef PC_ALIGN_CHECK_EN
                        mis_pend_next = mis_req;
`endif
                    end
                end else if (!stall) begin
                    pc_next = pc_plus4;
                end
            end
            PEND: begin
                // Younger requests arriving while pending are dropped.
                if (!stall) begin
                    pc_next    = tgt_reg;
                    flush_next = 1'b1;
                    state_next = RUN;
`ifdef PC_ALIGN_CHECK_EN
                    mis_next      = mis_pend_reg;
                    mis_pend_next = 1'b0;
`endif
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RUN;
            pc_reg    <= RESET_VEC;
            tgt_reg   <= '0;
            flush_reg <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            mis_pend_reg <= 1'b0;
            mis_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            tgt_reg   <= tgt_next;
            flush_reg <= flush_next;
`ifdef PC_ALIGN_CHECK_EN
            mis_pend_reg <= mis_pend_next;
            mis_reg      <= mis_next;
`endif
        end
    end

    assign pc            = pc_reg;
    assign if_id_flush   = flush_reg;
    assign redirect_pend = (state_reg == PEND);
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_exc  = mis_reg;
`endif

endmodule
